// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
//
// Purpose: FSM state encoding, word/lane geometry and wait-state limits used
// by dmem_responder and dmem_bank.
// Ports: none (package).

package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_W   = 32;
    localparam int LANES    = 4;
    localparam int LANE_W   = WORD_W / LANES;
    localparam int CNT_W    = 4;
    localparam int WAIT_MAX = 15;

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - synchronous byte-enable data RAM
//
// Purpose: single-port RAM with per-lane write enables and a registered,
// read-first output. No reset, so it maps onto block RAM.
// Ports:
//   clk    in            rising-edge clock
//   index  in DEPTH_LOG2 word index
//   we     in 1          write enable
//   be     in LANES      byte-lane enables, bit i -> wdata[8i+7:8i]
//   wdata  in WORD_W     write data, lane positioned
//   rdata  out WORD_W    RAM[index] as sampled on the last edge

module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic                  we,
    input  logic [LANES-1:0]      be,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    r_mem[index][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
        rdata <= r_mem[index];
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - configurable-latency data-memory responder
//
// Purpose: accepts one load/store request at a time from the memory stage,
// waits WAIT_CYCLES, performs the RAM access on the edge entering RESP and
// pulses mem_valid for one cycle. Loads return the whole aligned word.
// Ports:
//   clk          in  1   rising-edge clock
//   rst          in  1   asynchronous active-high reset
//   mem_request  in  1   request strobe, sampled while mem_ready=1
//   we_re        in  1   1 = store, 0 = load
//   addr         in  32  byte address (word index = addr[DEPTH_LOG2+1:2])
//   wdata        in  32  store data, lane positioned
//   mask         in  4   store byte enables
//   mem_ready    out 1   idle, request accepted this edge if mem_request=1
//   mem_valid    out 1   one-cycle completion strobe
//   rdata        out 32  last load word

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_request,
    input  logic              we_re,
    input  logic [31:0]       addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [LANES-1:0]  mask,
    output logic              mem_ready,
    output logic              mem_valid,
    output logic [WORD_W-1:0] rdata
);

    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);

    dmem_state_t             r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_we;
    logic [DEPTH_LOG2-1:0]   r_index;
    logic [WORD_W-1:0]       r_wdata;
    logic [LANES-1:0]        r_mask;
    logic [WORD_W-1:0]       r_rd_hold;
    logic                    r_ready;
    logic                    r_valid;

    logic                    w_accept;
    logic [DEPTH_LOG2-1:0]   w_addr_index;
    logic [DEPTH_LOG2-1:0]   w_bank_index;
    logic                    w_bank_we;
    logic [LANES-1:0]        w_bank_be;
    logic [WORD_W-1:0]       w_bank_wdata;
    logic [WORD_W-1:0]       w_bank_rdata;
    logic                    w_unused_addr;

    assign w_addr_index  = addr[DEPTH_LOG2+1:2];
    assign w_unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
    assign w_accept      = (r_state == ST_IDLE) && mem_request;

    // The access happens on the edge entering RESP. With no wait states that
    // edge is the accept edge itself, so the bank must see the live request
    // inputs; otherwise it sees the latched copy during the last WAIT cycle.
    // In IDLE the index follows addr so a zero-wait load reads the right word.
    assign w_bank_index = (r_state == ST_IDLE) ? w_addr_index : r_index;
    assign w_bank_we    = NO_WAIT ? (w_accept && we_re)
                                  : ((r_state == ST_WAIT) && (r_cnt == '0) && r_we);
    assign w_bank_be    = NO_WAIT ? mask  : r_mask;
    assign w_bank_wdata = NO_WAIT ? wdata : r_wdata;

    dmem_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk   (clk),
        .index (w_bank_index),
        .we    (w_bank_we),
        .be    (w_bank_be),
        .wdata (w_bank_wdata),
        .rdata (w_bank_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_index   <= '0;
            r_wdata   <= '0;
            r_mask    <= '0;
            r_rd_hold <= '0;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mem_request) begin
                        r_we    <= we_re;
                        r_index <= w_addr_index;
                        r_wdata <= wdata;
                        r_mask  <= mask;
                        r_ready <= 1'b0;
                        if (NO_WAIT) begin
                            r_state <= ST_RESP;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    if (!r_we) begin
                        r_rd_hold <= w_bank_rdata;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign mem_ready = r_ready;
    assign mem_valid = r_valid;

    // During a load's RESP cycle the fresh word is the bank's output register;
    // it is copied into the hold register on leaving RESP so rdata stays put
    // across stores and idle cycles.
    assign rdata = ((r_state == ST_RESP) && !r_we) ? w_bank_rdata : r_rd_hold;

endmodule
